// File: rtl/alu_muldiv_seq.sv
// Sequential 8051-style MUL AB / DIV AB engine.
// Shift-add multiply (LSB-first) and restoring divide (MSB-first), one step per clock.
// Optional build macro MULDIV_ZERO_SKIP_EN: zero operands (MUL) or a zero divisor (DIV)
// bypass the iteration loop and complete two edges after the start.
module alu_muldiv_seq #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable_mul,
  input  logic              enable_div,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  output logic [DATA_W-1:0] des1,
  output logic [DATA_W-1:0] des2,
  output logic              desOv,
  output logic              desCy,
  output logic              busy,
  output logic              done
);

  localparam int unsigned CNT_W = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic                is_mul_q;
  // MUL: shifting multiplicand; DIV: dividend in the low half, consumed from its MSB.
  logic [2*DATA_W-1:0] a_q, a_d;
  // MUL: multiplier shifted right each step; DIV: divisor, held constant.
  logic [DATA_W-1:0]   b_q, b_d;
  // MUL: product accumulator; DIV: {partial remainder, quotient}.
  logic [2*DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W:0]     partial;
  logic [DATA_W-1:0]   rem_n;
  logic                start;
  logic                last_iter;
  logic                skip;

  assign start     = enable_mul | enable_div;
  assign last_iter = (cnt_q == LastCnt);

`ifdef MULDIV_ZERO_SKIP_EN
  // Operands are still unshifted on the first RUN cycle, so test them only then.
  assign skip = (cnt_q == '0) &&
                (is_mul_q ? ((a_q[DATA_W-1:0] == '0) || (b_q == '0)) : (b_q == '0));
`else
  assign skip = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; starts are only accepted in idle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (skip || last_iter) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Status outputs decoded from the state.
  always_comb begin
    busy = (state_q != StIdle);
    done = (state_q == StDone);
  end

  // One multiply or divide iteration.
  always_comb begin
    acc_d   = acc_q;
    a_d     = a_q << 1;
    b_d     = b_q;
    partial = '0;
    rem_n   = '0;
    if (is_mul_q) begin
      acc_d = acc_q + (b_q[0] ? a_q : '0);
      b_d   = b_q >> 1;
    end else begin
      partial = {acc_q[2*DATA_W-1:DATA_W], a_q[DATA_W-1]};
      if (partial >= {1'b0, b_q}) begin
        // Remainder stays below the divisor, so the difference fits in DATA_W bits.
        rem_n = partial[DATA_W-1:0] - b_q;
        acc_d = {rem_n, acc_q[DATA_W-2:0], 1'b1};
      end else begin
        acc_d = {partial[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b0};
      end
    end
  end

  // Operand latching, iteration datapath and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      is_mul_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      des1     <= '0;
      des2     <= '0;
      desOv    <= 1'b0;
      desCy    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            is_mul_q <= enable_mul;
            a_q      <= {{DATA_W{1'b0}}, src1};
            b_q      <= src2;
            acc_q    <= '0;
            cnt_q    <= '0;
          end
        end
        StRun: begin
          acc_q <= acc_d;
          a_q   <= a_d;
          b_q   <= b_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (skip) begin
            des1  <= is_mul_q ? '0 : '1;
            des2  <= is_mul_q ? '0 : a_q[DATA_W-1:0];
            desOv <= ~is_mul_q;
            desCy <= 1'b0;
          end else if (last_iter) begin
            des1  <= acc_d[DATA_W-1:0];
            des2  <= acc_d[2*DATA_W-1:DATA_W];
            desOv <= is_mul_q ? (acc_d[2*DATA_W-1:DATA_W] != '0) : (b_q == '0);
            desCy <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Randomised and directed bench for alu_muldiv_seq (DATA_W = 8) against an arithmetic model.
module tb_alu_muldiv_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable_mul;
  logic       enable_div;
  logic [7:0] src1;
  logic [7:0] src2;
  logic [7:0] des1;
  logic [7:0] des2;
  logic       desOv;
  logic       desCy;
  logic       busy;
  logic       done;

  int n_chk = 0;
  int n_bad = 0;

  logic [7:0] last_des1 = '0;
  logic [7:0] last_des2 = '0;

  always #5 clk = ~clk;

  alu_muldiv_seq #(.DATA_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable_mul (enable_mul),
    .enable_div (enable_div),
    .src1       (src1),
    .src2       (src2),
    .des1       (des1),
    .des2       (des2),
    .desOv      (desOv),
    .desCy      (desCy),
    .busy       (busy),
    .done       (done)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // op: 0 = MUL, 1 = DIV, 2 = both enables (MUL must win).
  // poke: RUN cycle at which both enables pulse with new operands (-1 for none).
  task automatic run_op(input int op, input logic [7:0] a, input logic [7:0] b,
                        input int poke, input string tag);
    logic [15:0] prod;
    logic [7:0]  e1, e2;
    logic        eov;
    bit          is_mul;
    int          exp_lat;
    int          n;
    is_mul = (op != 1);
    if (is_mul) begin
      prod = 16'(a) * 16'(b);
      e1   = prod[7:0];
      e2   = prod[15:8];
      eov  = (prod > 16'd255);
    end else if (b == 0) begin
      e1  = 8'hFF;
      e2  = a;
      eov = 1'b1;
    end else begin
      e1  = a / b;
      e2  = a % b;
      eov = 1'b0;
    end
    exp_lat = 8;
`ifdef MULDIV_ZERO_SKIP_EN
    if (is_mul ? (a == 0 || b == 0) : (b == 0)) exp_lat = 1;
`endif
    src1       = a;
    src2       = b;
    enable_mul = (op != 1);
    enable_div = (op != 0);
    @(posedge clk);
    #1;
    enable_mul = 1'b0;
    enable_div = 1'b0;
    src1       = 8'($urandom);
    src2       = 8'($urandom);
    check_eq({tag, " busy_at_start"}, busy, 1);
    check_eq({tag, " des1_held"}, des1, last_des1);
    check_eq({tag, " des2_held"}, des2, last_des2);
    n = 0;
    while (!done && n < 40) begin
      if (n == poke) begin
        enable_mul = 1'b1;
        enable_div = 1'b1;
        src1       = 8'h10;
        src2       = 8'h02;
      end
      @(posedge clk);
      #1;
      enable_mul = 1'b0;
      enable_div = 1'b0;
      n++;
    end
    check_eq({tag, " latency"}, n, exp_lat);
    check_eq({tag, " des1"}, des1, e1);
    check_eq({tag, " des2"}, des2, e2);
    check_eq({tag, " desOv"}, desOv, eov);
    check_eq({tag, " desCy"}, desCy, 0);
    check_eq({tag, " busy_in_done"}, busy, 1);
    @(posedge clk);
    #1;
    check_eq({tag, " done_one_cycle"}, done, 0);
    check_eq({tag, " idle_after"}, busy, 0);
    last_des1 = e1;
    last_des2 = e2;
  endtask

  initial begin
    int extra;
    logic [7:0] ra, rb;
    int rop;
    rst        = 1'b1;
    enable_mul = 1'b0;
    enable_div = 1'b0;
    src1       = '0;
    src2       = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset des1", des1, 0);
    check_eq("reset des2", des2, 0);
    check_eq("reset desOv", desOv, 0);
    check_eq("reset desCy", desCy, 0);
    check_eq("reset busy", busy, 0);
    check_eq("reset done", done, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_op(0, 8'h0C, 8'h15, -1, "mul_0c_15");
    run_op(0, 8'hFF, 8'hFF, -1, "mul_ff_ff");
    run_op(1, 8'h64, 8'h07, -1, "div_64_07");
    run_op(1, 8'h05, 8'h09, -1, "div_05_09");
    run_op(1, 8'h5A, 8'h00, -1, "div_by_zero");
    run_op(0, 8'h00, 8'h37, -1, "mul_zero");
    run_op(0, 8'h03, 8'h04, 3, "mul_poked");
    // No second completion may follow the ignored mid-run start.
    extra = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done) extra++;
    end
    check_eq("poke no_second_done", extra, 0);
    run_op(2, 8'h07, 8'h09, -1, "both_enables");

    // Abort a divide mid-run.
    src1       = 8'h64;
    src2       = 8'h07;
    enable_div = 1'b1;
    @(posedge clk);
    #1;
    enable_div = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("abort busy", busy, 0);
    check_eq("abort done", done, 0);
    check_eq("abort des1", des1, 0);
    check_eq("abort des2", des2, 0);
    check_eq("abort desOv", desOv, 0);
    extra = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done || busy) extra++;
    end
    check_eq("abort quiet", extra, 0);
    last_des1 = '0;
    last_des2 = '0;
    run_op(0, 8'h02, 8'h03, -1, "mul_after_abort");

    for (int i = 0; i < 40; i++) begin
      rop = int'($urandom_range(0, 2));
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      if ($urandom_range(0, 4) == 0) rb = 8'h00;
      if ($urandom_range(0, 7) == 0) ra = 8'h00;
      run_op(rop, ra, rb, -1, "rand");
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
